// File: rtl/m10k_pkg.sv
// Shared definitions for the source M10K producer/consumer pair.
// Holds default widths and the loader phase encoding so every consumer of
// the busy/start status decodes the loader phases the same way.
package m10k_pkg;

  localparam int M10K_DATA_W = 8;
  localparam int M10K_ADDR_W = 8;

  // Loader phases: filling the frame, draining the last write, handing off, waiting on compute
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FLUSH = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/source_frame_loader.sv
// Purpose: streams FRAME_LEN signed samples into the source M10K, then hands the frame to compute.
// Latency: an accepted sample is on the M10K write port the next cycle; start pulses 2 cycles after the last accept.
// Backpressure: in_ready is high only in LOAD; input is held off from frame completion until compute_done.
module source_frame_loader
  import m10k_pkg::*;
#(
  parameter int DATA_W    = M10K_DATA_W,
  parameter int ADDR_W    = M10K_ADDR_W,
  parameter int FRAME_LEN = 256,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] M10K_write_data_source,
  output logic        [ADDR_W-1:0] M10K_write_address_source,
  output logic                     M10K_write_source,
  output logic                     start,
  input  logic                     compute_done,
  output logic                     busy,
  output logic        [CNT_W-1:0]  frame_count
);

  // Address of the final sample of a frame; FRAME_LEN may be as large as 2^ADDR_W
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  loader_state_t     state;
  loader_state_t     state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic              accept;
  logic              last_slot;
  logic              release_frame;

  assign accept        = in_valid & in_ready;
  assign last_slot     = (wr_ptr == LAST_ADDR);
  assign release_frame = (state == WAIT) & compute_done;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: compute_done only matters once the frame has been handed off
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (accept && last_slot) state_nxt = FLUSH;
      FLUSH:   state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (compute_done) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Status outputs decoded from the state register only; ready is held low while reset is asserted
  always_comb begin
    in_ready = 1'b0;
    start    = 1'b0;
    busy     = 1'b1;
    case (state)
      LOAD: begin
        in_ready = reset;
        busy     = 1'b0;
      end
      START:   start = 1'b1;
      default: ;
    endcase
  end

  // Write pointer: advances per accept, rewinds to 0 after the last sample of the frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
    end else if (accept) begin
      wr_ptr <= last_slot ? '0 : wr_ptr + ADDR_W'(1);
    end
  end

  // Registered M10K write port: strobe for one cycle per accept, address/data hold between writes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      M10K_write_source         <= 1'b0;
      M10K_write_address_source <= '0;
      M10K_write_data_source    <= '0;
    end else begin
      M10K_write_source <= accept;
      if (accept) begin
        M10K_write_address_source <= wr_ptr;
        M10K_write_data_source    <= in_data;
      end
    end
  end

  // Completed-frame counter, bumped when compute releases the frame; wraps silently
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_count <= '0;
    end else if (release_frame) begin
      frame_count <= frame_count + CNT_W'(1);
    end
  end

endmodule
